// File: rtl/spm_cfg_sequencer.sv
// Scratchpad configuration sequencer: loads a session of instruction words into the
// scratchpad buffer through init/inst, then strobes run once per loaded word.
module spm_cfg_sequencer #(
   parameter int INST_W = 24,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  cfg_len_i,
   input  logic              cfg_valid_i,
   input  logic [INST_W-1:0] cfg_data_i,
   output logic              cfg_ready_o,
   input  logic              pause_i,
   output logic              spm_init_o,
   output logic [INST_W-1:0] spm_inst_o,
   output logic              spm_run_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        state_o
);

   // Handshake: a config beat transfers on any clock edge where cfg_valid_i and
   // cfg_ready_o are both high; cfg_ready_o depends only on state and counters.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_FIN  = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic [CNT_W-1:0]    load_cnt_q, load_cnt_d;
   logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
   logic                used_q, used_d;
   logic                init_q, init_d;
   logic [INST_W-1:0]   inst_q, inst_d;
   logic                run_q, run_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                ready;
   logic                len_bad;

   assign ready   = (state_q == S_LOAD) && (load_cnt_q < len_q);
   assign len_bad = (cfg_len_i == '0) || (cfg_len_i > DEPTH_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         load_cnt_q <= '0;
         run_cnt_q  <= '0;
         used_q     <= 1'b0;
         init_q     <= 1'b0;
         inst_q     <= '0;
         run_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         load_cnt_q <= load_cnt_d;
         run_cnt_q  <= run_cnt_d;
         used_q     <= used_d;
         init_q     <= init_d;
         inst_q     <= inst_d;
         run_q      <= run_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      load_cnt_d = load_cnt_q;
      run_cnt_d  = run_cnt_q;
      used_d     = used_q;
      init_d     = 1'b0;
      inst_d     = inst_q;
      run_d      = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               // The scratchpad run pointer only clears on rst, so one session per reset.
               if (len_bad || used_q) begin
                  err_d = 1'b1;
               end else begin
                  len_d      = cfg_len_i;
                  load_cnt_d = '0;
                  run_cnt_d  = '0;
                  busy_d     = 1'b1;
                  state_d    = S_LOAD;
               end
            end
         end

         S_LOAD: begin
            if (cfg_valid_i && ready) begin
               init_d     = 1'b1;
               inst_d     = cfg_data_i;
               load_cnt_d = load_cnt_q + ONE_C;
               if (load_cnt_q == len_q - ONE_C) begin
                  state_d = S_RUN;
               end
            end
         end

         S_RUN: begin
            if (!pause_i && (run_cnt_q < len_q)) begin
               run_d     = 1'b1;
               run_cnt_d = run_cnt_q + ONE_C;
               if (run_cnt_q == len_q - ONE_C) begin
                  used_d  = 1'b1;
                  state_d = S_FIN;
               end
            end
         end

         S_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign cfg_ready_o = ready;
   assign spm_init_o  = init_q;
   assign spm_inst_o  = inst_q;
   assign spm_run_o   = run_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_spm_cfg_sequencer.sv
// Bench for spm_cfg_sequencer: table of sessions with randomized valid gaps and pauses,
// checked cycle by cycle against a count-based session model.
module tb_spm_cfg_sequencer;

   localparam int INST_W = 24;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = 5;

   logic              clk;
   logic              rst;
   logic              start;
   logic [CNT_W-1:0]  cfg_len;
   logic              cfg_valid;
   logic [INST_W-1:0] cfg_data;
   logic              cfg_ready;
   logic              pause;
   logic              spm_init;
   logic [INST_W-1:0] spm_inst;
   logic              spm_run;
   logic              busy;
   logic              done;
   logic              err;
   logic [1:0]        state_dbg;

   spm_cfg_sequencer #(.INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .cfg_len_i   (cfg_len),
      .cfg_valid_i (cfg_valid),
      .cfg_data_i  (cfg_data),
      .cfg_ready_o (cfg_ready),
      .pause_i     (pause),
      .spm_init_o  (spm_init),
      .spm_inst_o  (spm_inst),
      .spm_run_o   (spm_run),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err),
      .state_o     (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // session model: counts of words loaded and runs issued
   bit                m_active, m_used, m_run_ok, m_done_arm;
   int                m_len, m_loaded, m_runs;
   bit                e_init, e_run, e_done, e_err, e_busy;
   logic [INST_W-1:0] e_inst;
   logic [INST_W-1:0] exp_q[$];

   int obs_init, obs_run, obs_done, obs_err;

   typedef struct {
      logic [CNT_W-1:0] len;
      int               valid_pct;   // -1: valid toggles 1,0,1,0
      int               pause_pct;
      int               pause_hold;  // pause forced high this many cycles at run entry
      bit               fixed_data;
      bit               rst_first;
      bit               exp_err;
      int               exp_init;
      int               exp_run;
      int               exp_done;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_active = 0; m_used = 0; m_run_ok = 0; m_done_arm = 0;
      m_len = 0; m_loaded = 0; m_runs = 0;
      e_init = 0; e_run = 0; e_done = 0; e_err = 0; e_busy = 0;
      e_inst = '0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_valid = 1'b0; cfg_data = '0; pause = 1'b0;
      tick();
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_spm_init", spm_init, 0);
      chk("rst_spm_inst", spm_inst, 0);
      chk("rst_spm_run", spm_run, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      model_clear();
   endtask

   // compare this cycle's outputs, drive inputs, advance the model one clock
   task automatic cycle(input bit st, input logic [CNT_W-1:0] ln, input bit v,
                        input logic [INST_W-1:0] d, input bit p);
      bit ready_exp, acc, n_init, n_run, n_done, n_err, n_busy;
      ready_exp = m_active && (m_loaded < m_len);
      chk("cfg_ready", cfg_ready, ready_exp);
      chk("spm_init", spm_init, e_init);
      chk("spm_inst", spm_inst, e_inst);
      chk("spm_run", spm_run, e_run);
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("busy", busy, e_busy);
      obs_init += int'(spm_init);
      obs_run  += int'(spm_run);
      obs_done += int'(done);
      obs_err  += int'(err);

      start = st; cfg_len = ln; cfg_valid = v; cfg_data = d; pause = p;

      acc    = v && ready_exp;
      n_init = acc;
      if (acc) begin
         exp_q.push_back(d);
         m_loaded++;
      end
      n_run = m_run_ok && !p && (m_runs < m_len);
      if (n_run) m_runs++;
      n_done     = m_done_arm;
      m_done_arm = n_run && (m_runs == m_len);
      m_run_ok   = m_run_ok || (acc && (m_loaded == m_len));
      n_err  = 0;
      n_busy = e_busy;
      if (st && !m_active) begin
         if (ln == 0 || int'(ln) > DEPTH || m_used) begin
            n_err = 1;
         end else begin
            m_active = 1; m_len = int'(ln); m_loaded = 0; m_runs = 0; m_run_ok = 0;
            n_busy = 1;
         end
      end
      if (n_done) begin
         n_busy = 0; m_active = 0; m_used = 1;
      end

      tick();
      e_init = n_init; e_run = n_run; e_done = n_done; e_err = n_err; e_busy = n_busy;
      if (n_init) e_inst = exp_q.pop_front();
   endtask

   task automatic run_vec(input vec_t t);
      int  c, held, tail;
      bit  v, p;
      logic [INST_W-1:0] d;
      if (t.rst_first) do_reset();
      obs_init = 0; obs_run = 0; obs_done = 0; obs_err = 0;
      cycle(1'b1, t.len, 1'b0, '0, 1'b0);
      held = 0;
      tail = 0;
      c    = 0;
      while (c < 400 && tail < 3) begin
         if (t.valid_pct < 0) v = (c % 2 == 0);
         else                 v = ($urandom_range(99, 0) < t.valid_pct);
         d = t.fixed_data ? INST_W'(24'h000111 * (m_loaded + 1)) : INST_W'($urandom);
         if (m_run_ok && held < t.pause_hold) begin
            p = 1'b1;
            held++;
         end else begin
            p = ($urandom_range(99, 0) < t.pause_pct);
         end
         cycle(1'b0, '0, v, d, p);
         if (obs_done > 0 || t.exp_err || t.exp_done == 0) tail++;
         c++;
      end
      chk("n_err", obs_err, t.exp_err);
      chk("n_init", obs_init, t.exp_init);
      chk("n_run", obs_run, t.exp_run);
      chk("n_done", obs_done, t.exp_done);
   endtask

   initial begin
      vec_t t;
      int   l;
      rst = 1'b1; start = 0; cfg_len = '0; cfg_valid = 0; cfg_data = '0; pause = 0;
      model_clear();

      //           len  vpct pp hold fix rst  err init run done
      tbl[0]  = '{5'd3,  100, 0, 0, 1, 1, 0, 3, 3, 1};
      tbl[1]  = '{5'd4,   -1, 0, 0, 0, 1, 0, 4, 4, 1};
      tbl[2]  = '{5'd2,  100, 0, 3, 0, 1, 0, 2, 2, 1};
      tbl[3]  = '{5'd0,  100, 0, 0, 0, 1, 1, 0, 0, 0};
      tbl[4]  = '{5'd17, 100, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[5]  = '{5'd1,  100, 0, 0, 0, 1, 0, 1, 1, 1};
      tbl[6]  = '{5'd1,  100, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[7]  = '{5'd1,  100, 0, 0, 0, 1, 0, 1, 1, 1};
      tbl[8]  = '{5'd16,  60,30, 0, 0, 1, 0,16,16, 1};
      tbl[9]  = '{5'd31, 100, 0, 0, 0, 1, 1, 0, 0, 0};
      for (int i = 10; i < 16; i++) begin
         l = $urandom_range(DEPTH, 1);
         tbl[i] = '{CNT_W'(l), $urandom_range(90, 25), $urandom_range(60, 0),
                    $urandom_range(3, 0), 0, 1, 0, l, l, 1};
      end

      do_reset();
      for (int i = 0; i < 16; i++) begin
         t = tbl[i];
         run_vec(t);
      end

      // abort mid-load after two of five words; a stray start while busy is ignored
      do_reset();
      obs_init = 0; obs_run = 0; obs_done = 0; obs_err = 0;
      cycle(1'b1, 5'd5, 1'b0, '0, 1'b0);
      cycle(1'b1, 5'd0, 1'b1, 24'hABCDEF, 1'b0);
      for (int k = 0; k < 20 && m_loaded < 2; k++) cycle(1'b0, '0, 1'b1, INST_W'($urandom), 1'b0);
      cycle(1'b0, '0, 1'b0, '0, 1'b0);
      chk("abort_loaded", obs_init, 2);
      do_reset();
      for (int k = 0; k < 6; k++) cycle(1'b0, '0, 1'b1, '0, 1'b0);
      chk("abort_no_done", obs_done, 0);
      chk("abort_no_err", obs_err, 0);
      chk("abort_no_run", obs_run, 0);
      t = '{5'd3, 70, 20, 0, 0, 0, 0, 3, 3, 1};
      run_vec(t);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
